sha_msg_schedule: RTL and testbench

- SHA-256 message-schedule functional unit; the producer end of the W/K word stream consumed by the compression-round unit (xunitF in8/in9).
- Takes 16 message words, one per cycle, and emits W[0..63] with the matching K[t], one pair per cycle.
- Sits in the Versat datapath beside xunitF. Uses the same run/delay/done FU conventions so its out0/out1 wire directly to xunitF in8/in9.

---
 rtl/sha_pkg.sv | 45 ++++
 rtl/sha_k_rom.sv | 12 +
 rtl/sha_msg_schedule.sv | 163 ++++++++++++++++
 tb/tb_sha_msg_schedule.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word width, schedule FSM encoding, the round
// constant table K and the message-schedule sigma functions.
package sha_pkg;

   localparam int DATA_W     = 32;
   localparam int ROUNDS_MAX = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_LOAD   = 2'd2,
      ST_EXPAND = 2'd3
   } state_t;

   // FIPS 180-4 round constants K[0..63]
   localparam logic [31:0] K_TABLE [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

endpackage

// File: rtl/sha_k_rom.sv
// SHA-256 round-constant ROM: combinational lookup of K[addr].
// Only instantiated when SHA_MSG_SCHEDULE_KROM_EN is defined.
module sha_k_rom
   import sha_pkg::*;
(
   input  logic [5:0]        addr,
   output logic [DATA_W-1:0] k
);

   assign k = K_TABLE[addr];

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-256 message-schedule functional unit. Loads 16 message words, one per
// cycle, then expands them to W[0..ROUNDS-1], emitting each W[t] on out0 with
// K[t] on out1 in the same cycle.
// Build option: SHA_MSG_SCHEDULE_KROM_EN -- when defined, an internal K ROM
// drives out1; when undefined, out1 stays 0 and K is supplied externally.
module sha_msg_schedule #(
   parameter int DATA_W  = 32,
   parameter int ROUNDS  = 64,
   parameter int DELAY_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [DATA_W-1:0]  in0,
   input  logic [DELAY_W-1:0] delay0,
   output logic [DATA_W-1:0]  out0,
   output logic [DATA_W-1:0]  out1,
   output logic               done
);
   import sha_pkg::*;

   localparam logic [5:0] LAST_T      = 6'(ROUNDS - 1);
   localparam logic [5:0] LAST_LOAD_T = 6'd15;
   localparam logic       SKIP_EXPAND = (ROUNDS == 16);

   state_t              state;
   state_t              state_next;
   logic [5:0]          t;
   logic [5:0]          t_next;
   logic [DELAY_W-1:0]  cnt;
   logic [DELAY_W-1:0]  cnt_next;
   logic [DATA_W-1:0]   out0_next;
   logic [DATA_W-1:0]   out1_next;
   logic                done_next;
   logic                shift_en;
   logic [DATA_W-1:0]   new_word;
   logic [DATA_W-1:0]   expand_word;
   logic [DATA_W-1:0]   k_word;

   // win[0] holds W[t-16], win[15] holds W[t-1]
   logic [DATA_W-1:0]   win [16];

`ifdef SHA_MSG_SCHEDULE_KROM_EN
   sha_k_rom u_k_rom (
      .addr (t),
      .k    (k_word)
   );
`else
   assign k_word = {DATA_W{1'b0}};
`endif

   assign expand_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

   // Next-state, round counter and output selection; a run pulse restarts from any state
   always_comb begin
      state_next = state;
      t_next     = t;
      cnt_next   = cnt;
      out0_next  = out0;
      out1_next  = out1;
      done_next  = done;
      shift_en   = 1'b0;
      new_word   = expand_word;

      if (run) begin
         t_next    = 6'd0;
         cnt_next  = delay0;
         done_next = 1'b0;
         if (delay0 != {DELAY_W{1'b0}}) begin
            state_next = ST_DELAY;
         end else begin
            state_next = ST_LOAD;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               done_next = 1'b1;
            end
            ST_DELAY: begin
               done_next = 1'b0;
               cnt_next  = cnt - DELAY_W'(1);
               if (cnt <= DELAY_W'(1)) begin
                  state_next = ST_LOAD;
               end else begin
                  state_next = ST_DELAY;
               end
            end
            ST_LOAD: begin
               done_next = 1'b0;
               shift_en  = 1'b1;
               new_word  = in0;
               out0_next = in0;
               out1_next = k_word;
               if (t == LAST_LOAD_T) begin
                  if (SKIP_EXPAND) begin
                     state_next = ST_IDLE;
                     t_next     = 6'd0;
                  end else begin
                     state_next = ST_EXPAND;
                     t_next     = t + 6'd1;
                  end
               end else begin
                  t_next = t + 6'd1;
               end
            end
            ST_EXPAND: begin
               done_next = 1'b0;
               shift_en  = 1'b1;
               out0_next = expand_word;
               out1_next = k_word;
               if (t == LAST_T) begin
                  state_next = ST_IDLE;
                  t_next     = 6'd0;
               end else begin
                  t_next = t + 6'd1;
               end
            end
            default: begin
               state_next = ST_IDLE;
               t_next     = 6'd0;
            end
         endcase
      end
   end

   // Control and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         t     <= 6'd0;
         cnt   <= {DELAY_W{1'b0}};
         out0  <= {DATA_W{1'b0}};
         out1  <= {DATA_W{1'b0}};
         done  <= 1'b1;
      end else begin
         state <= state_next;
         t     <= t_next;
         cnt   <= cnt_next;
         out0  <= out0_next;
         out1  <= out1_next;
         done  <= done_next;
      end
   end

   // 16-word message window, shifted once per emitted word
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            win[i] <= {DATA_W{1'b0}};
         end
      end else if (shift_en) begin
         for (int i = 0; i < 15; i++) begin
            win[i] <= win[i+1];
         end
         win[15] <= new_word;
      end else begin
         for (int i = 0; i < 16; i++) begin
            win[i] <= win[i];
         end
      end
   end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Self-checking bench for sha_msg_schedule: scoreboard of expected (W[t], K[t])
// pairs built from an independent schedule model, plus reset, delay, restart
// and end-of-run checks.
module tb_sha_msg_schedule;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [31:0] in0 = 32'd0;
   logic [7:0]  delay0 = 8'd0;
   logic [31:0] out0;
   logic [31:0] out1;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          t;
      logic [31:0] w;
      logic [31:0] k;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] cur_msg [16];
   logic [31:0] w_exp [64];
   logic [31:0] last_w = 32'd0;
   logic [31:0] last_k = 32'd0;
   logic        is_abc = 1'b0;

   sha_msg_schedule #(.DATA_W(32), .ROUNDS(64), .DELAY_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .in0    (in0),
      .delay0 (delay0),
      .out0   (out0),
      .out1   (out1),
      .done   (done)
   );

   always #5 clk = ~clk;

`ifdef SHA_MSG_SCHEDULE_KROM_EN
   logic [31:0] k_ref [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   function automatic logic [31:0] k_exp(input int t);
      return k_ref[t];
   endfunction
`else
   function automatic logic [31:0] k_exp(input int t);
      return (t >= 0) ? 32'd0 : 32'd0;
   endfunction
`endif

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference schedule computed straight from the SHA-256 definition
   task automatic build_model();
      for (int i = 0; i < 16; i++) w_exp[i] = cur_msg[i];
      for (int i = 16; i < 64; i++) begin
         logic [31:0] s0, s1;
         s0 = rotr(w_exp[i-15], 7) ^ rotr(w_exp[i-15], 18) ^ (w_exp[i-15] >> 3);
         s1 = rotr(w_exp[i-2], 17) ^ rotr(w_exp[i-2], 19) ^ (w_exp[i-2] >> 10);
         w_exp[i] = s1 + w_exp[i-7] + s0 + w_exp[i-16];
      end
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_abc();
      for (int i = 0; i < 16; i++) cur_msg[i] = 32'd0;
      cur_msg[0]  = 32'h61626380;
      cur_msg[15] = 32'h00000018;
      is_abc = 1'b1;
      build_model();
   endtask

   task automatic load_random();
      for (int i = 0; i < 16; i++) cur_msg[i] = $urandom();
      is_abc = 1'b0;
      build_model();
   endtask

   // Spot values of the "abc" schedule, independent of the model
   task automatic abc_spot(input int t);
      case (t)
         0:  check_eq("abc_W0",  out0, 32'h61626380);
         15: check_eq("abc_W15", out0, 32'h00000018);
         16: check_eq("abc_W16", out0, 32'h61626380);
         17: check_eq("abc_W17", out0, 32'h000F0000);
         18: check_eq("abc_W18", out0, 32'h7DA86405);
         19: check_eq("abc_W19", out0, 32'h600003C6);
         63: check_eq("abc_W63", out0, 32'h12B1EDEB);
         default: ;
      endcase
`ifdef SHA_MSG_SCHEDULE_KROM_EN
      case (t)
         0:  check_eq("K0",  out1, 32'h428A2F98);
         1:  check_eq("K1",  out1, 32'h71374491);
         63: check_eq("K63", out1, 32'hC67178F2);
         default: ;
      endcase
`endif
   endtask

   // Pulse run, wait out the delay, then stream words 0..stop_t through the scoreboard
   task automatic run_msg(input logic [7:0] d, input int stop_t);
      exp_t e;
      in0    = $urandom();
      delay0 = d;
      run    = 1'b1;
      tick();
      run    = 1'b0;
      delay0 = $urandom_range(0, 255);
      check_eq("done_fall", {31'd0, done}, 32'd0);
      for (int i = 0; i < d; i++) begin
         tick();
         check_eq("delay_hold_w", out0, last_w);
         check_eq("delay_busy", {31'd0, done}, 32'd0);
      end
      for (int t = 0; t <= stop_t; t++) begin
         in0 = (t < 16) ? cur_msg[t] : $urandom();
         sb.push_back('{t, w_exp[t], k_exp(t)});
         tick();
         if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check_eq($sformatf("W%0d", e.t), out0, e.w);
            check_eq($sformatf("K%0d", e.t), out1, e.k);
            check_eq($sformatf("busy%0d", e.t), {31'd0, done}, 32'd0);
            last_w = e.w;
            last_k = e.k;
         end
         if (is_abc) abc_spot(t);
      end
   endtask

   // After the last word: done rises one cycle later and outputs hold
   task automatic end_checks();
      tick();
      check_eq("done_rise", {31'd0, done}, 32'd1);
      check_eq("hold_w", out0, last_w);
      check_eq("hold_k", out1, last_k);
      tick();
      check_eq("idle_done", {31'd0, done}, 32'd1);
      check_eq("idle_hold_w", out0, last_w);
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_out0", out0, 32'd0);
      check_eq("rst_out1", out1, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd1);

      // "abc", no delay
      load_abc();
      run_msg(8'd0, 63);
      end_checks();

      // "abc", delay0 = 5
      run_msg(8'd5, 63);
      end_checks();

      // reset in the middle of a run
      run_msg(8'd0, 30);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_out0", out0, 32'd0);
      check_eq("midrst_out1", out1, 32'd0);
      check_eq("midrst_done", {31'd0, done}, 32'd1);
      last_w = 32'd0;
      last_k = 32'd0;
      run_msg(8'd0, 63);
      end_checks();

      // restart at t=40 with a new random message
      run_msg(8'd2, 40);
      load_random();
      run_msg(8'd0, 63);
      end_checks();

      // restart in the same cycle the final word would be produced
      load_random();
      run_msg(8'd0, 62);
      load_random();
      run_msg(8'd3, 63);
      end_checks();

      // delay0 = 1 corner
      load_abc();
      run_msg(8'd1, 63);
      end_checks();

      check_eq("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
